conv_mem_arbiter: RTL and testbench

Shares one single-port synchronous SRAM (the convolution feature/weight buffer) between the three read streams and the one write stream produced by the convolution address controller. Each cycle it grants at most one requester, drives a registered SRAM command, and returns read data tagged to the requester that issued it. Writes have priority, bounded by a starvation limit. Reads are round-robin among the three streams.

---
 rtl/conv_mem_arbiter_if.sv | 43 ++++
 rtl/conv_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_conv_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mem_arbiter_if.sv
// Request/grant and SRAM command bundle for the convolution buffer arbiter.
// slave: arbiter side; master: requesters plus SRAM model side.
interface conv_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          en;
  logic [2:0]    rd_req;
  logic [3*AW-1:0] rd_addr;
  logic [2:0]    rd_gnt;
  logic [2:0]    rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  en, rd_req, rd_addr,
    input  wr_req, wr_addr, wr_data,
    input  mem_rdata,
    output rd_gnt, rd_valid, rd_data,
    output wr_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output en, rd_req, rd_addr,
    output wr_req, wr_addr, wr_data,
    output mem_rdata,
    input  rd_gnt, rd_valid, rd_data,
    input  wr_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/conv_mem_arbiter.sv
// Single-port SRAM arbiter: one write stream with bounded priority over
// three round-robin read streams, registered command, tagged read return.
module conv_mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int STARVE = 4
) (
  input logic clk,
  input logic rst,
  conv_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

  logic [1:0]    r_rr_ptr;
  logic [SW-1:0] r_streak;
  logic [2:0]    r_tag1;
  logic [2:0]    r_tag2;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic          w_any_rd;
  logic          w_arb_ok;
  logic          w_starved;
  logic          w_wr_gnt;
  logic [2:0]    w_rd_gnt;
  logic [1:0]    w_rd_sel;
  logic          w_any_gnt;
  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] w_gnt_addr;
  logic [1:0]    w_rr_nxt;
  logic [SW-1:0] w_streak_nxt;

  assign w_any_rd  = |bus.rd_req;
  assign w_arb_ok  = bus.en && !rst;
  assign w_starved = w_any_rd && (r_streak == STARVE_C);
  assign w_wr_gnt  = w_arb_ok && bus.wr_req && !w_starved;

  // Search order starts at r_rr_ptr and wraps modulo 3.
  always_comb begin
    logic found;
    logic [2:0] s;
    found    = 1'b0;
    s        = 3'd0;
    w_rd_gnt = 3'b000;
    w_rd_sel = 2'd0;
    if (w_arb_ok && !w_wr_gnt && w_any_rd) begin
      for (int k = 0; k < 3; k++) begin
        s = {1'b0, r_rr_ptr} + 3'(k);
        if (s >= 3'd3) s = s - 3'd3;
        if (!found && bus.rd_req[s[1:0]]) begin
          found    = 1'b1;
          w_rd_sel = s[1:0];
        end
      end
      w_rd_gnt[w_rd_sel] = found;
    end
  end

  assign w_any_gnt = w_wr_gnt || (|w_rd_gnt);

  always_comb begin
    w_rd_addr = bus.rd_addr[0 +: AW];
    unique case (1'b1)
      (w_rd_sel == 2'd1): w_rd_addr = bus.rd_addr[AW +: AW];
      (w_rd_sel == 2'd2): w_rd_addr = bus.rd_addr[2*AW +: AW];
      default:            w_rd_addr = bus.rd_addr[0 +: AW];
    endcase
  end

  assign w_gnt_addr = w_wr_gnt ? bus.wr_addr : w_rd_addr;

  always_comb begin
    w_rr_nxt = r_rr_ptr;
    if (|w_rd_gnt)
      w_rr_nxt = (w_rd_sel == 2'd2) ? 2'd0 : w_rd_sel + 2'd1;
  end

  // Streak only counts writes that actually made a reader wait.
  always_comb begin
    w_streak_nxt = r_streak;
    if (!w_any_rd || (|w_rd_gnt))
      w_streak_nxt = '0;
    else if (w_wr_gnt && r_streak != STARVE_C)
      w_streak_nxt = r_streak + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 2'd0;
      r_streak <= '0;
    end else begin
      r_rr_ptr <= w_rr_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_any_gnt;
      r_mem_we <= w_wr_gnt;
      if (w_any_gnt) begin
        r_mem_addr  <= w_gnt_addr;
        r_mem_wdata <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag1 <= 3'b000;
      r_tag2 <= 3'b000;
    end else begin
      r_tag1 <= w_rd_gnt;
      r_tag2 <= r_tag1;
    end
  end

  assign bus.rd_gnt    = w_rd_gnt;
  assign bus.wr_gnt    = w_wr_gnt;
  assign bus.rd_valid  = r_tag2;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = w_any_rd || bus.wr_req ||
                         (|r_tag1) || (|r_tag2);
endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed bench for conv_mem_arbiter with an SRAM model and a
// read-return scoreboard keyed on stream, data and arrival cycle.
module tb_conv_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [2:0]  v;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  logic [31:0] mem [0:1023];
  bit          memv [0:1023];

  conv_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  conv_mem_arbiter #(.AW(AW), .DW(DW), .STARVE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD : (a ^ 32'h5A5A_0000);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr[11:2]]  <= bus.mem_wdata;
        memv[bus.mem_addr[11:2]] <= 1'b1;
      end else begin
        bus.mem_rdata <= memv[bus.mem_addr[11:2]] ?
                         mem[bus.mem_addr[11:2]] :
                         data_of(bus.mem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] v, input logic [31:0] d);
    exp_t e;
    e.v = v;
    e.d = d;
    e.c = cyc + 2;
    q.push_back(e);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].c <= cyc) begin
      m_e = q.pop_front();
      chk("rd_valid", 64'(bus.rd_valid), 64'(m_e.v));
      chk("rd_data", 64'(bus.rd_data), 64'(m_e.d));
    end else if (bus.rd_valid !== 3'b000) begin
      chk("rd_valid_unexp", 64'(bus.rd_valid), 64'd0);
    end
  end

  logic [2:0]  g;
  logic [31:0] a;

  initial begin
    bus.en        = 1'b1;
    bus.rd_req    = 3'b000;
    bus.rd_addr   = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.mem_rdata = '0;

    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("idle_mem_en", 64'(bus.mem_en), 64'd0);
      chk("idle_mem_we", 64'(bus.mem_we), 64'd0);
      chk("idle_addr", 64'(bus.mem_addr), 64'd0);
      chk("idle_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("idle_gnt", 64'({bus.rd_gnt, bus.wr_gnt}), 64'd0);
      chk("idle_busy", 64'(bus.busy), 64'd0);
    end

    // single read
    tick();
    bus.rd_req = 3'b010;
    bus.rd_addr[AW +: AW] = 32'h40;
    #1;
    chk("sr_gnt", 64'(bus.rd_gnt), 64'(3'b010));
    chk("sr_busy", 64'(bus.busy), 64'd1);
    push(3'b010, 32'hDEAD);
    tick();
    bus.rd_req = 3'b000;
    #1;
    chk("sr_mem_en", 64'(bus.mem_en), 64'd1);
    chk("sr_mem_we", 64'(bus.mem_we), 64'd0);
    chk("sr_addr", 64'(bus.mem_addr), 64'h40);
    repeat (3) tick();

    // round robin
    do_reset();
    bus.rd_addr = {32'h300, 32'h200, 32'h100};
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.rd_req = 3'b111;
      #1;
      g = 3'b001 << (k % 3);
      a = 32'((k % 3) + 1) << 8;
      chk("rr_gnt", 64'(bus.rd_gnt), 64'(g));
      chk("rr_wgnt", 64'(bus.wr_gnt), 64'd0);
      if (k > 0)
        chk("rr_addr", 64'(bus.mem_addr), 64'((32'(((k - 1) % 3) + 1)) << 8));
      push(g, data_of(a));
    end
    tick();
    bus.rd_req = 3'b000;
    repeat (3) tick();

    // starvation bound
    do_reset();
    bus.rd_addr[0 +: AW] = 32'h500;
    bus.wr_addr = 32'h600;
    for (int k = 0; k < 9; k++) begin
      tick();
      bus.rd_req  = 3'b001;
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'h1000 + 32'(k);
      #1;
      if (k == 4) begin
        chk("st_rgnt", 64'(bus.rd_gnt), 64'(3'b001));
        chk("st_wgnt", 64'(bus.wr_gnt), 64'd0);
        push(3'b001, data_of(32'h500));
      end else begin
        chk("st_wgnt", 64'(bus.wr_gnt), 64'd1);
        chk("st_rgnt", 64'(bus.rd_gnt), 64'd0);
      end
    end
    tick();
    bus.rd_req = 3'b000;
    bus.wr_req = 1'b0;
    repeat (3) tick();

    // write then read back
    tick();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 32'h10;
    bus.wr_data = 32'hCAFE;
    #1;
    chk("wr_gnt", 64'(bus.wr_gnt), 64'd1);
    tick();
    bus.wr_req = 1'b0;
    #1;
    chk("wr_mem_en", 64'(bus.mem_en), 64'd1);
    chk("wr_mem_we", 64'(bus.mem_we), 64'd1);
    chk("wr_addr", 64'(bus.mem_addr), 64'h10);
    chk("wr_wdata", 64'(bus.mem_wdata), 64'hCAFE);
    repeat (2) tick();
    bus.rd_req = 3'b100;
    bus.rd_addr[2*AW +: AW] = 32'h10;
    #1;
    chk("rb_gnt", 64'(bus.rd_gnt), 64'(3'b100));
    push(3'b100, 32'hCAFE);
    tick();
    bus.rd_req = 3'b000;
    repeat (3) tick();

    // en drop after a read grant
    bus.rd_req = 3'b001;
    bus.rd_addr[0 +: AW] = 32'h700;
    #1;
    chk("en_gnt0", 64'(bus.rd_gnt), 64'(3'b001));
    push(3'b001, data_of(32'h700));
    for (int k = 1; k < 3; k++) begin
      tick();
      bus.en     = 1'b0;
      bus.wr_req = 1'b1;
      #1;
      chk("en_off_gnt", 64'({bus.rd_gnt, bus.wr_gnt}), 64'd0);
    end
    tick();
    bus.en     = 1'b1;
    bus.rd_req = 3'b000;
    bus.wr_req = 1'b0;
    repeat (3) tick();

    // reset mid-flight drops the pending read
    bus.rd_req = 3'b001;
    bus.rd_addr[0 +: AW] = 32'h800;
    #1;
    chk("rs_gnt0", 64'(bus.rd_gnt), 64'(3'b001));
    tick();
    rst        = 1'b1;
    bus.rd_req = 3'b000;
    #1;
    chk("rs_gnt1", 64'({bus.rd_gnt, bus.wr_gnt}), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rs_valid", 64'(bus.rd_valid), 64'd0);
    chk("rs_busy", 64'(bus.busy), 64'd0);
    chk("rs_mem_en", 64'(bus.mem_en), 64'd0);
    repeat (4) tick();

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
